// File: rtl/bcd_countdown_if.sv
// Control and data bundle for bcd_countdown: load/start/enable in, BCD count and status out.
interface bcd_countdown_if #(
   parameter int unsigned DIGITS = 2
);
   logic                  load;
   logic [4*DIGITS-1:0]   load_value;
   logic                  start;
   logic                  enable;
   logic [4*DIGITS-1:0]   digits;
   logic                  busy;
   logic                  zero;
   logic                  done;

   modport master (
      output load, load_value, start, enable,
      input  digits, busy, zero, done
   );

   modport slave (
      input  load, load_value, start, enable,
      output digits, busy, zero, done
   );
endinterface

// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with IDLE/RUN/DONE control and a registered one-cycle done pulse.
// Optional BCD_COUNTDOWN_AUTORELOAD_EN: on 1->0 in RUN, reload the start value and keep running.
module bcd_countdown #(
   parameter int unsigned DIGITS = 2
) (
   input  logic             clock,
   input  logic             reset,
   bcd_countdown_if.slave   bus
);
   localparam int unsigned W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   digits_q, digits_d;
   logic [W-1:0]   reload_q, reload_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic           zero_w;
   logic           one_w;

   function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   // Digit 0 always borrows in; a zero digit under borrow becomes 9 and passes the borrow on.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      logic [3:0]   nib;
      r      = v;
      borrow = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         nib = v[4*i +: 4];
         if (borrow) begin
            if (nib == 4'd0) begin
               nib = 4'd9;
            end else begin
               nib    = nib - 4'd1;
               borrow = 1'b0;
            end
         end
         r[4*i +: 4] = nib;
      end
      return r;
   endfunction

   assign zero_w = (digits_q == '0);
   assign one_w  = (digits_q == W'(1));

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (bus.load) begin
         digits_d = bcd_clamp(bus.load_value);
         reload_d = bcd_clamp(bus.load_value);
         state_d  = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (zero_w) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               if (bus.enable && !zero_w) begin
                  if (one_w) begin
                     done_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                     if (reload_q != '0) begin
                        digits_d = reload_q;
                     end else begin
                        digits_d = '0;
                        state_d  = DONE;
                     end
`else
                     digits_d = '0;
                     state_d  = DONE;
`endif
                  end else begin
                     digits_d = bcd_dec(digits_q);
                  end
               end
            end
            DONE: begin
               if (bus.start) begin
                  if (reload_q == '0) begin
                     done_d = 1'b1;
                  end else begin
                     digits_d = reload_q;
                     state_d  = RUN;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         digits_q <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         reload_q <= reload_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.digits = digits_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.zero   = zero_w;
endmodule
